// File: rtl/cpu_sequencer_if.sv
// ============================================================================
// Module      : cpu_sequencer_if
// Description : Instruction-memory, control-unit and status signals of the
//               CPU fetch/decode/execute sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_sequencer_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 3
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  pc;
    logic               cu_en;
    logic               bra;
    logic [ADDR_W-1:0]  badr;
    logic               hlt;
    logic [CNT_W-1:0]   exec_cycles;
    logic               stall;
    logic               pc_en;
    logic               irq;
    logic               irq_ack;
    logic [ADDR_W-1:0]  epc;
    logic               halted;
    logic [2:0]         state;

    modport master (
        output imem_req, imem_addr, ir, pc, cu_en, pc_en, irq_ack, epc, halted, state,
        input  imem_ready, imem_data, bra, badr, hlt, exec_cycles, stall, irq
    );

    modport slave (
        input  imem_req, imem_addr, ir, pc, cu_en, pc_en, irq_ack, epc, halted, state,
        output imem_ready, imem_data, bra, badr, hlt, exec_cycles, stall, irq
    );
endinterface

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ============================================================================
// Module      : cpu_sequencer
// Description : Fetch/decode/execute sequencer owning PC and IR, with memory
//               wait states, multi-cycle execute, halt and interrupt entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_sequencer #(
    parameter int                ADDR_W    = 10,
    parameter int                INSTR_W   = 16,
    parameter int                CNT_W     = 3,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       IRQ_VEC   = 32'h3F0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    cpu_sequencer_if.master        bus
);

    localparam logic [ADDR_W-1:0] c_irq_vec = ADDR_W'(IRQ_VEC);
    localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);
    localparam logic [ADDR_W-1:0] c_pc_one  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_IRQ     = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [ADDR_W-1:0]  r_epc;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [INSTR_W-1:0] w_ir_nxt;
    logic [ADDR_W-1:0]  w_epc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_pc_en;
    logic               w_irq_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RESET;
            r_pc    <= RESET_VEC;
            r_ir    <= '0;
            r_epc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_epc   <= w_epc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_epc_nxt   = r_epc;
        w_cnt_nxt   = r_cnt;
        w_pc_en     = 1'b0;
        w_irq_ack   = 1'b0;

        case (r_state)
            S_RESET: begin
                w_state_nxt = S_FETCH;
            end

            S_FETCH: begin
                if (bus.imem_ready) begin
                    w_ir_nxt    = bus.imem_data;
                    w_state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                if (bus.hlt) begin
                    w_state_nxt = S_HALT;
                end else if (bus.bra) begin
                    w_pc_nxt    = bus.badr;
                    w_pc_en     = 1'b1;
                    w_state_nxt = bus.irq ? S_IRQ : S_FETCH;
                end else begin
                    w_cnt_nxt   = (bus.exec_cycles == '0) ? c_cnt_one : bus.exec_cycles;
                    w_state_nxt = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                if (!bus.stall) begin
                    // Counter of 0 cannot occur here; treat it like the last cycle.
                    if (r_cnt > c_cnt_one) begin
                        w_cnt_nxt = r_cnt - c_cnt_one;
                    end else begin
                        w_pc_nxt    = r_pc + c_pc_one;
                        w_pc_en     = 1'b1;
                        w_state_nxt = bus.irq ? S_IRQ : S_FETCH;
                    end
                end
            end

            S_IRQ: begin
                w_epc_nxt   = r_pc;
                w_pc_nxt    = c_irq_vec;
                w_pc_en     = 1'b1;
                w_irq_ack   = 1'b1;
                w_state_nxt = S_FETCH;
            end

            S_HALT: begin
                // Wake-up returns past the halt instruction, bypassing S_IRQ.
                if (bus.irq) begin
                    w_epc_nxt   = r_pc + c_pc_one;
                    w_pc_nxt    = c_irq_vec;
                    w_pc_en     = 1'b1;
                    w_irq_ack   = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end

            default: begin
                w_state_nxt = S_RESET;
            end
        endcase
    end

    assign bus.imem_req  = (r_state == S_FETCH);
    assign bus.cu_en     = (r_state == S_DECODE);
    assign bus.halted    = (r_state == S_HALT);
    assign bus.irq_ack   = w_irq_ack;
    assign bus.pc_en     = w_pc_en;
    assign bus.imem_addr = r_pc;
    assign bus.pc        = r_pc;
    assign bus.ir        = r_ir;
    assign bus.epc       = r_epc;
    assign bus.state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Randomised instruction-level bench for cpu_sequencer with a
//               per-instruction expected phase/PC model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_sequencer;

    localparam int          c_aw   = 10;
    localparam logic [9:0]  c_irqv = 10'h3F0;
    localparam logic [9:0]  c_rv   = 10'h000;

    localparam logic [2:0] c_st_reset = 3'd0;
    localparam logic [2:0] c_st_fetch = 3'd1;
    localparam logic [2:0] c_st_dec   = 3'd2;
    localparam logic [2:0] c_st_exec  = 3'd3;
    localparam logic [2:0] c_st_irq   = 3'd4;
    localparam logic [2:0] c_st_halt  = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_sequencer_if #(.ADDR_W(c_aw), .INSTR_W(16), .CNT_W(3)) bus ();

    cpu_sequencer #(
        .ADDR_W    (c_aw),
        .INSTR_W   (16),
        .CNT_W     (3),
        .RESET_VEC (c_rv),
        .IRQ_VEC   (32'h3F0)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model: what PC/EPC/IR must be between clock edges
    logic [9:0]  m_pc;
    logic [9:0]  m_epc;
    logic [15:0] m_ir;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input logic [2:0] st, input logic pen, input logic ack);
        check("state",     32'(bus.state),     32'(st));
        check("imem_req",  32'(bus.imem_req),  32'(st == c_st_fetch));
        check("cu_en",     32'(bus.cu_en),     32'(st == c_st_dec));
        check("halted",    32'(bus.halted),    32'(st == c_st_halt));
        check("irq_ack",   32'(bus.irq_ack),   32'(ack));
        check("pc_en",     32'(bus.pc_en),     32'(pen));
        check("pc",        32'(bus.pc),        32'(m_pc));
        check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
        check("epc",       32'(bus.epc),       32'(m_epc));
        check("ir",        32'(bus.ir),        32'(m_ir));
    endtask

    task automatic idle_inputs();
        bus.imem_ready  = 1'b0;
        bus.imem_data   = '0;
        bus.bra         = 1'b0;
        bus.badr        = '0;
        bus.hlt         = 1'b0;
        bus.exec_cycles = '0;
        bus.stall       = 1'b0;
        bus.irq         = 1'b0;
    endtask

    // Asserts rst away from the clock edge and checks that it acts at once.
    task automatic do_reset();
        rst = 1'b1;
        settle();
        m_pc  = c_rv;
        m_epc = '0;
        m_ir  = '0;
        chk(c_st_reset, 1'b0, 1'b0);
        next_cycle();
        chk(c_st_reset, 1'b0, 1'b0);
        rst = 1'b0;
        settle();
        chk(c_st_reset, 1'b0, 1'b0);
        next_cycle();
    endtask

    // One instruction from the first FETCH cycle up to the next FETCH.
    task automatic run_instr(input int w, input logic [15:0] data, input logic b,
                             input logic h, input logic [9:0] ba, input logic [2:0] ec,
                             input logic [15:0] smask, input logic irq_end,
                             input int halt_wait);
        int   rem;
        int   k;
        logic last;
        logic go_irq;
        go_irq = 1'b0;

        for (int i = 0; i <= w; i++) begin
            bus.imem_ready = (i == w);
            bus.imem_data  = (i == w) ? data : 16'($urandom);
            bus.irq        = 1'($urandom);
            settle();
            chk(c_st_fetch, 1'b0, 1'b0);
            next_cycle();
        end
        m_ir = data;
        bus.imem_ready = 1'b0;
        bus.imem_data  = 16'($urandom);

        bus.bra         = b;
        bus.hlt         = h;
        bus.badr        = ba;
        bus.exec_cycles = ec;
        bus.irq         = (b && !h) ? irq_end : 1'($urandom);
        settle();
        chk(c_st_dec, b && !h, 1'b0);
        next_cycle();
        bus.bra         = 1'($urandom);
        bus.hlt         = 1'($urandom);
        bus.badr        = 10'($urandom);
        bus.exec_cycles = 3'($urandom);

        if (h) begin
            for (int i = 0; i < halt_wait; i++) begin
                bus.irq = 1'b0;
                settle();
                chk(c_st_halt, 1'b0, 1'b0);
                next_cycle();
            end
            bus.irq = 1'b1;
            settle();
            chk(c_st_halt, 1'b1, 1'b1);
            m_epc = m_pc + 10'd1;
            m_pc  = c_irqv;
            next_cycle();
        end else if (b) begin
            m_pc   = ba;
            go_irq = irq_end;
        end else begin
            rem = (ec == 3'd0) ? 1 : int'(ec);
            k   = 0;
            while (rem > 0) begin
                bus.stall = (k < 16) ? smask[k] : 1'b0;
                last      = !bus.stall && (rem == 1);
                bus.irq   = last ? irq_end : 1'($urandom);
                settle();
                chk(c_st_exec, last, 1'b0);
                if (!bus.stall) rem--;
                k++;
                next_cycle();
            end
            bus.stall = 1'b0;
            m_pc   = m_pc + 10'd1;
            go_irq = irq_end;
        end

        if (go_irq) begin
            bus.irq = 1'b0;
            settle();
            chk(c_st_irq, 1'b1, 1'b1);
            m_epc = m_pc;
            m_pc  = c_irqv;
            next_cycle();
        end
        bus.irq = 1'b0;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        repeat (3) run_instr(0, 16'h0400, 1'b0, 1'b0, 10'h000, 3'd1, 16'h0, 1'b0, 0);
        run_instr(3, 16'hBEEF, 1'b0, 1'b0, 10'h000, 3'd1, 16'h0, 1'b0, 0);
        run_instr(0, 16'h1234, 1'b1, 1'b0, 10'h155, 3'd2, 16'h0, 1'b0, 0);
        run_instr(0, 16'h5678, 1'b1, 1'b1, 10'h0AA, 3'd2, 16'h0, 1'b0, 3);
        run_instr(1, 16'h2222, 1'b0, 1'b0, 10'h000, 3'd4, 16'b0110, 1'b0, 0);
        run_instr(0, 16'h3333, 1'b0, 1'b0, 10'h000, 3'd0, 16'h0, 1'b0, 0);
        run_instr(0, 16'h4444, 1'b1, 1'b0, 10'h3FF, 3'd0, 16'h0, 1'b0, 0);
        run_instr(0, 16'h5555, 1'b0, 1'b0, 10'h000, 3'd2, 16'h0, 1'b0, 0);
        run_instr(0, 16'h6666, 1'b1, 1'b0, 10'h020, 3'd0, 16'h0, 1'b0, 0);
        run_instr(2, 16'h7777, 1'b0, 1'b0, 10'h000, 3'd3, 16'h0, 1'b1, 0);
        run_instr(0, 16'h8888, 1'b1, 1'b0, 10'h030, 3'd0, 16'h0, 1'b0, 0);
        run_instr(0, 16'h9999, 1'b0, 1'b1, 10'h000, 3'd0, 16'h0, 1'b0, 2);

        repeat (80) begin
            run_instr(int'($urandom_range(0, 3)), 16'($urandom),
                      1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                      10'($urandom), 3'($urandom), 16'($urandom) & 16'h00FF,
                      1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 2; i++) begin
            bus.imem_ready = 1'b0;
            settle();
            chk(c_st_fetch, 1'b0, 1'b0);
            next_cycle();
        end
        do_reset();
        run_instr(1, 16'hA5A5, 1'b0, 1'b0, 10'h000, 3'd1, 16'h0, 1'b0, 0);
        settle();
        chk(c_st_fetch, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
